vending_machine: RTL and testbench



---
 rtl/vending_machine.sv | 117 +++++++++++
 tb/tb_vending_machine.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/vending_machine.sv
`default_nettype none
// ============================================================================
//  Module   : vending_machine
//  Purpose  : Coin-accepting controller for a single-product vending machine.
//             The product costs 15 units. The machine accepts 5-unit and
//             10-unit coins (one coin event per clock) and a cancel request.
//             When the held credit reaches 15 it issues a one-cycle dispense
//             pulse. Overpay (10 + 10) dispenses and returns 5 in the same
//             cycle. Cancel refunds the whole held credit.
//  Ports    : clk     - system clock, all state updates on the rising edge
//             rst     - synchronous, active-high reset (priority over in)
//             in      - coin code: 00 none, 01 five, 10 ten, 11 cancel
//             out     - registered dispense pulse, high for one cycle
//             change  - registered change/refund code, valid for one cycle:
//                       00 none, 01 five, 10 ten (11 never driven)
//  Revision : 1.0 - initial release
// ============================================================================
module vending_machine (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    output logic       out,
    output logic [1:0] change
);

    // Coin codes presented by the validator front end
    localparam logic [1:0] c_IN_NONE   = 2'b00;
    localparam logic [1:0] c_IN_FIVE   = 2'b01;
    localparam logic [1:0] c_IN_TEN    = 2'b10;
    localparam logic [1:0] c_IN_CANCEL = 2'b11;

    // Change codes driven to the refund actuator
    localparam logic [1:0] c_CHG_NONE  = 2'b00;
    localparam logic [1:0] c_CHG_FIVE  = 2'b01;
    localparam logic [1:0] c_CHG_TEN   = 2'b10;

    // Each state records the credit held so far. Encoding 2'b11 is unused
    // and falls back to S0 through the default branch.
    typedef enum logic [1:0] {
        S0  = 2'b00,
        S5  = 2'b01,
        S10 = 2'b10
    } state_t;

    state_t     r_state;
    logic       r_out;
    logic [1:0] r_change;

    // Single registered FSM: next state and both outputs are computed from
    // the current state and the sampled coin code. Outputs default to idle
    // every edge so each pulse lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Credit is discarded without refund; in is ignored entirely.
            r_state  <= S0;
            r_out    <= 1'b0;
            r_change <= c_CHG_NONE;
        end else begin
            r_out    <= 1'b0;
            r_change <= c_CHG_NONE;
            case (r_state)
                S0: begin
                    case (in)
                        c_IN_FIVE:   r_state <= S5;
                        c_IN_TEN:    r_state <= S10;
                        // Cancel with no credit has nothing to refund
                        c_IN_CANCEL: r_state <= S0;
                        default:     r_state <= S0;
                    endcase
                end
                S5: begin
                    case (in)
                        c_IN_NONE: r_state <= S5;
                        c_IN_FIVE: r_state <= S10;
                        c_IN_TEN: begin
                            r_state <= S0;
                            r_out   <= 1'b1;
                        end
                        default: begin
                            // Cancel: refund the held 5
                            r_state  <= S0;
                            r_change <= c_CHG_FIVE;
                        end
                    endcase
                end
                S10: begin
                    case (in)
                        c_IN_NONE: r_state <= S10;
                        c_IN_FIVE: begin
                            r_state <= S0;
                            r_out   <= 1'b1;
                        end
                        c_IN_TEN: begin
                            // Overpay to 20: dispense and return 5 together
                            r_state  <= S0;
                            r_out    <= 1'b1;
                            r_change <= c_CHG_FIVE;
                        end
                        default: begin
                            // Cancel: refund the held 10
                            r_state  <= S0;
                            r_change <= c_CHG_TEN;
                        end
                    endcase
                end
                default: begin
                    r_state <= S0;
                end
            endcase
        end
    end

    assign out    = r_out;
    assign change = r_change;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vending_machine
//  Purpose  : Self-checking bench for vending_machine. A credit-counting
//             reference model (plain integer arithmetic) predicts the
//             dispense pulse and change code for every cycle; directed
//             sequences are followed by a long randomized coin stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vending_machine;

    logic       clk;
    logic       rst;
    logic [1:0] in;
    logic       out;
    logic [1:0] change;

    int n_checks;
    int n_errors;

    // Reference model state: credit in units, predicted registered outputs
    int         m_credit;
    logic       m_out;
    logic [1:0] m_change;

    vending_machine u_dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in),
        .out    (out),
        .change (change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: accumulate coin value; at 15 or more dispense and
    // return the excess; cancel returns all held credit.
    task automatic model_step(input logic r, input logic [1:0] c);
        m_out    = 1'b0;
        m_change = 2'b00;
        if (r) begin
            m_credit = 0;
        end else begin
            case (c)
                2'b01: m_credit += 5;
                2'b10: m_credit += 10;
                2'b11: begin
                    m_change = 2'((m_credit / 5));
                    m_credit = 0;
                end
                default: ;
            endcase
            if (m_credit >= 15) begin
                m_out    = 1'b1;
                m_change = 2'(((m_credit - 15) / 5));
                m_credit = 0;
            end
        end
    endtask

    // Called at a falling edge: drive inputs, let the rising edge happen,
    // then compare at the next falling edge.
    task automatic cycle(input logic r, input logic [1:0] c, input string tag);
        rst = r;
        in  = c;
        @(posedge clk);
        model_step(r, c);
        @(negedge clk);
        chk({tag, ".out"},    {7'd0, out}, {7'd0, m_out});
        chk({tag, ".change"}, {6'd0, change}, {6'd0, m_change});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_credit = 0;
        m_out    = 1'b0;
        m_change = 2'b00;
        rst      = 1'b1;
        in       = 2'bxx;

        @(negedge clk);
        // Reset with undriven coin input
        cycle(1'b1, 2'bxx, "reset");
        chk("reset.out_const", {7'd0, out}, 8'd0);
        chk("reset.chg_const", {6'd0, change}, 8'd0);

        // Three 5-unit coins, then idle
        cycle(1'b0, 2'b01, "five1");
        cycle(1'b0, 2'b01, "five2");
        cycle(1'b0, 2'b01, "five3");
        chk("five3.dispense", {7'd0, out}, 8'd1);
        cycle(1'b0, 2'b00, "five_idle");
        chk("five_idle.pulse_end", {7'd0, out}, 8'd0);

        // 5 then 10, and 10 then 5
        cycle(1'b0, 2'b01, "f10a");
        cycle(1'b0, 2'b10, "f10b");
        cycle(1'b0, 2'b10, "t5a");
        cycle(1'b0, 2'b01, "t5b");

        // Overpay: dispense with change 01
        cycle(1'b0, 2'b10, "over_a");
        cycle(1'b0, 2'b10, "over_b");
        chk("over.change5", {6'd0, change}, 8'd1);

        // Cancels: from S10, S5, S0
        cycle(1'b0, 2'b10, "can10a");
        cycle(1'b0, 2'b11, "can10b");
        chk("can10.refund10", {6'd0, change}, 8'd2);
        cycle(1'b0, 2'b01, "can5a");
        cycle(1'b0, 2'b11, "can5b");
        cycle(1'b0, 2'b11, "can0");

        // Credit held through idle cycles, no dispense
        cycle(1'b0, 2'b01, "hold1");
        cycle(1'b0, 2'b00, "hold2");
        cycle(1'b0, 2'b00, "hold3");
        cycle(1'b0, 2'b01, "hold4");
        // Reset mid-transaction discards the 10, then a 10 alone does nothing
        cycle(1'b1, 2'b10, "rst_mid");
        cycle(1'b0, 2'b10, "post_rst");
        // Held credit is 10 now; a 5 proves no stale credit survived reset
        cycle(1'b0, 2'b01, "post_rst5");

        // Coin right after a dispense starts a fresh transaction
        cycle(1'b0, 2'b10, "b2b1");
        cycle(1'b0, 2'b01, "b2b2");
        cycle(1'b0, 2'b10, "b2b3");
        cycle(1'b0, 2'b10, "b2b4");

        // Randomized coin stream with occasional reset
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [1:0] c;
            r = ($urandom_range(0, 49) == 0);
            c = 2'($urandom_range(0, 3));
            cycle(r, c, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
